// File: rtl/router_input_unit_if.sv
// rtl/router_input_unit_if.sv - link, arbiter and crossbar signals of one router input port
interface router_input_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OUT_PORT_BITS = 3
);
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     request;
  logic [OUT_PORT_BITS-1:0] req_port;
  logic                     grant;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;

  // master: upstream link plus arbiter/crossbar side; slave: the input unit
  modport master (
    output in_data, in_valid, grant,
    input  in_ready, request, req_port, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, grant,
    output in_ready, request, req_port, out_data, out_valid
  );
endinterface

// File: rtl/router_input_unit.sv
// rtl/router_input_unit.sv - per-input flit FIFO with XY route computation for the mesh router
module router_input_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int PTR_BITS      = 2,
  parameter int OUT_PORT_BITS = 3,
  parameter int X_BITS        = 4,
  parameter int Y_BITS        = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0
) (
  input logic                clk,
  input logic                reset,
  router_input_unit_if.slave bus
);
  localparam logic [PTR_BITS:0]      DEPTH_CNT = (PTR_BITS+1)'(FIFO_DEPTH);
  localparam logic [X_BITS-1:0]      RX        = X_BITS'(ROUTER_X);
  localparam logic [Y_BITS-1:0]      RY        = Y_BITS'(ROUTER_Y);
  localparam logic [OUT_PORT_BITS-1:0] PORT_LOCAL = OUT_PORT_BITS'(0);
  localparam logic [OUT_PORT_BITS-1:0] PORT_NORTH = OUT_PORT_BITS'(1);
  localparam logic [OUT_PORT_BITS-1:0] PORT_SOUTH = OUT_PORT_BITS'(2);
  localparam logic [OUT_PORT_BITS-1:0] PORT_EAST  = OUT_PORT_BITS'(3);
  localparam logic [OUT_PORT_BITS-1:0] PORT_WEST  = OUT_PORT_BITS'(4);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [PTR_BITS:0]     count;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [X_BITS-1:0]     dx;
  logic [Y_BITS-1:0]     dy;
  logic [OUT_PORT_BITS-1:0] route;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign push  = bus.in_valid & ~full;
  // a grant while empty is ignored rather than corrupting the pointers
  assign pop   = ~empty & bus.grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign head = mem[rd_ptr];
  assign dx   = head[DATA_WIDTH-1 -: X_BITS];
  assign dy   = head[DATA_WIDTH-X_BITS-1 -: Y_BITS];

  // X is resolved completely before Y is considered, keeping the mesh deadlock-free
  always_comb begin
    route = PORT_LOCAL;
    if (dx > RX)      route = PORT_EAST;
    else if (dx < RX) route = PORT_WEST;
    else if (dy > RY) route = PORT_NORTH;
    else if (dy < RY) route = PORT_SOUTH;
  end

  assign bus.in_ready  = ~full;
  assign bus.request   = ~empty;
  assign bus.req_port  = empty ? PORT_LOCAL : route;
  assign bus.out_data  = head;
  assign bus.out_valid = pop;
endmodule
